// File: rtl/ctrlseq_pkg.sv
// Shared encodings for the 8085-style control sequencer: ienb/chk_i bit positions,
// T-state and machine-cycle codes.
package ctrlseq_pkg;

  localparam int unsigned IENBSIZE = 6;
  localparam int unsigned INSTSIZE = 17;

  localparam int unsigned IENB_RRD = 0;
  localparam int unsigned IENB_RWR = 1;
  localparam int unsigned IENB_COD = 2;
  localparam int unsigned IENB_DAT = 3;
  localparam int unsigned IENB_PC  = 4;
  localparam int unsigned IENB_PD  = 5;

  localparam int unsigned INST_GO6    = 0;
  localparam int unsigned INST_DAD    = 1;
  localparam int unsigned INST_HLT    = 2;
  localparam int unsigned INST_DIO    = 3;
  localparam int unsigned INST_CYC_LO = 4;
  localparam int unsigned INST_RW_LO  = 8;
  localparam int unsigned INST_CD_LO  = 12;
  localparam int unsigned INST_CCC    = 16;

  localparam logic [2:0] TS_T1   = 3'd0;
  localparam logic [2:0] TS_T2   = 3'd1;
  localparam logic [2:0] TS_TW   = 3'd2;
  localparam logic [2:0] TS_T3   = 3'd3;
  localparam logic [2:0] TS_T4   = 3'd4;
  localparam logic [2:0] TS_T5   = 3'd5;
  localparam logic [2:0] TS_T6   = 3'd6;
  localparam logic [2:0] TS_THLT = 3'd7;

  localparam logic [2:0] MC_M1 = 3'd0;
  localparam logic [2:0] MC_M2 = 3'd1;
  localparam logic [2:0] MC_M3 = 3'd2;
  localparam logic [2:0] MC_M4 = 3'd3;
  localparam logic [2:0] MC_M5 = 3'd4;

  // Per-cycle 4-bit fields (cyc/rw/cd) of the decoded instruction word.
  function automatic logic [3:0] inst_field(input logic [INSTSIZE-1:0] chk,
                                            input int unsigned lo);
    return chk[lo +: 4];
  endfunction

endpackage

// File: rtl/ctrlseq_if.sv
// Bus between the control sequencer and the ALU/register block plus external strobes.
interface ctrlseq_if;
  import ctrlseq_pkg::*;

  logic                ready;
  logic [INSTSIZE-1:0] chk_i;
  logic [IENBSIZE-1:0] ienb;
  logic                ale;
  logic                rd_;
  logic                wr_;
  logic                iom;
  logic                s1;
  logic                s0;
  logic                hlta;
  logic [2:0]          mcyc;

  modport master (
    input  ready, chk_i,
    output ienb, ale, rd_, wr_, iom, s1, s0, hlta, mcyc
  );

  modport slave (
    output ready, chk_i,
    input  ienb, ale, rd_, wr_, iom, s1, s0, hlta, mcyc
  );

endinterface

// File: rtl/ctrlseq_cycattr.sv
// Attributes of the current machine cycle derived from the latched instruction fields.
module ctrlseq_cycattr
  import ctrlseq_pkg::*;
(
  input  logic [2:0] mcyc,
  input  logic [3:0] cyc,
  input  logic [3:0] rw,
  input  logic [3:0] cd,
  input  logic       dio,
  output logic       is_last,
  output logic       is_write,
  output logic       use_hl,
  output logic       is_io
);

  // Field bit k describes machine cycle M(k+2).
  always_comb begin
    is_last  = 1'b1;
    is_write = 1'b0;
    use_hl   = 1'b0;
    is_io    = 1'b0;
    case (mcyc)
      MC_M1: is_last = ~cyc[0];
      MC_M2: begin
        is_last  = ~cyc[1];
        is_write = rw[0];
        use_hl   = cd[0];
      end
      MC_M3: begin
        is_last  = ~cyc[2];
        is_write = rw[1];
        use_hl   = cd[1];
        is_io    = dio;
      end
      MC_M4: begin
        is_last  = ~cyc[3];
        is_write = rw[2];
        use_hl   = cd[2];
      end
      MC_M5: begin
        is_write = rw[3];
        use_hl   = cd[3];
      end
      default: is_last = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrlseq.sv
// 8085-style timing/control sequencer: M1..M5 / T1..T6 FSM with wait states and halt,
// driving the ALU/register enables and the external bus strobes.
module ctrlseq
  import ctrlseq_pkg::*;
(
  input logic       clk,
  input logic       rst_,
  ctrlseq_if.master bus
);

  logic [2:0] t_q, t_d, m_q, m_d, m_next;
  logic       run_q;
  logic [3:0] cyc_q, rw_q, cd_q, cyc_eff;
  logic       dio_q;
  logic       is_last, is_write, use_hl, is_io;
  logic       in_t13, strobe, chk_go6, chk_hlt;

  logic [IENBSIZE-1:0] ienb;
  logic                ale, rd_n, wr_n, iom, hlta;
  logic [1:0]          st;

  assign chk_go6 = bus.chk_i[INST_GO6];
  assign chk_hlt = bus.chk_i[INST_HLT];
  // In M1 T4 the instruction word is live but not yet latched.
  assign cyc_eff = (t_q == TS_T4) ? inst_field(bus.chk_i, INST_CYC_LO) : cyc_q;

  ctrlseq_cycattr u_cycattr (
    .mcyc     (m_q),
    .cyc      (cyc_eff),
    .rw       (rw_q),
    .cd       (cd_q),
    .dio      (dio_q),
    .is_last  (is_last),
    .is_write (is_write),
    .use_hl   (use_hl),
    .is_io    (is_io)
  );

  assign m_next = is_last ? MC_M1 : m_q + 3'd1;

  always_comb begin
    t_d = t_q;
    m_d = m_q;
    case (t_q)
      TS_T1:        if (run_q) t_d = TS_T2;
      TS_T2, TS_TW: t_d = bus.ready ? TS_T3 : TS_TW;
      TS_T3: begin
        if (m_q == MC_M1) begin
          t_d = TS_T4;
        end else begin
          t_d = TS_T1;
          m_d = m_next;
        end
      end
      TS_T4: begin
        if (chk_hlt) begin
          t_d = TS_THLT;
        end else if (chk_go6) begin
          t_d = TS_T5;
        end else begin
          t_d = TS_T1;
          m_d = m_next;
        end
      end
      TS_T5: t_d = TS_T6;
      TS_T6: begin
        t_d = TS_T1;
        m_d = m_next;
      end
      TS_THLT: t_d = TS_THLT;
      default: begin
        t_d = TS_T1;
        m_d = MC_M1;
      end
    endcase
  end

  // run_q keeps the first clock after reset idle so T1 is only entered from a clean start.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      t_q   <= TS_T1;
      m_q   <= MC_M1;
      run_q <= 1'b0;
      cyc_q <= 4'd0;
      rw_q  <= 4'd0;
      cd_q  <= 4'd0;
      dio_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      t_q   <= t_d;
      m_q   <= m_d;
      if (t_q == TS_T4) begin
        cyc_q <= inst_field(bus.chk_i, INST_CYC_LO);
        rw_q  <= inst_field(bus.chk_i, INST_RW_LO);
        cd_q  <= inst_field(bus.chk_i, INST_CD_LO);
        dio_q <= bus.chk_i[INST_DIO];
      end
    end
  end

  assign in_t13 = (t_q == TS_T1) || (t_q == TS_T2) || (t_q == TS_TW) || (t_q == TS_T3);
  assign strobe = (t_q == TS_T2) || (t_q == TS_TW) || (t_q == TS_T3);

  always_comb begin
    ienb = '0;
    ale  = 1'b0;
    rd_n = 1'b1;
    wr_n = 1'b1;
    iom  = 1'b0;
    hlta = 1'b0;
    st   = 2'b11;
    if (run_q) begin
      if (t_q == TS_THLT) begin
        hlta = 1'b1;
        st   = 2'b00;
      end else if (m_q == MC_M1) begin
        ale  = (t_q == TS_T1);
        rd_n = ~strobe;
        if (t_q == TS_T3) begin
          ienb[IENB_COD] = 1'b1;
          ienb[IENB_PC]  = 1'b1;
        end
        if (is_last && (((t_q == TS_T4) && !chk_go6 && !chk_hlt) || (t_q == TS_T6))) begin
          ienb[IENB_RRD] = 1'b1;
          ienb[IENB_RWR] = 1'b1;
        end
      end else begin
        ale           = (t_q == TS_T1);
        iom           = is_io;
        ienb[IENB_PD] = use_hl && in_t13;
        if (is_write) begin
          st             = 2'b01;
          wr_n           = ~strobe;
          ienb[IENB_RRD] = in_t13;
        end else begin
          st   = 2'b10;
          rd_n = ~strobe;
          if (t_q == TS_T3) begin
            ienb[IENB_DAT] = 1'b1;
            ienb[IENB_PC]  = ~use_hl;
            ienb[IENB_RWR] = is_last;
          end
        end
      end
    end
  end

  assign bus.ienb = ienb;
  assign bus.ale  = ale;
  assign bus.rd_  = rd_n;
  assign bus.wr_  = wr_n;
  assign bus.iom  = iom;
  assign bus.s1   = st[1];
  assign bus.s0   = st[0];
  assign bus.hlta = hlta;
  assign bus.mcyc = m_q;

endmodule

// File: tb/tb_ctrlseq.sv
// Bench for ctrlseq: a per-instruction schedule of expected clock-by-clock outputs is
// generated from the machine-cycle rules and compared against the DUT.
module tb_ctrlseq;
  import ctrlseq_pkg::*;

  localparam logic [5:0] B_RRD = 6'b000001;
  localparam logic [5:0] B_RWR = 6'b000010;
  localparam logic [5:0] B_COD = 6'b000100;
  localparam logic [5:0] B_DAT = 6'b001000;
  localparam logic [5:0] B_PC  = 6'b010000;
  localparam logic [5:0] B_PD  = 6'b100000;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct packed {
    logic [15:0] exp;
    logic        rdy;
    logic [16:0] chk;
  } step_t;

  logic clk  = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  ctrlseq_if bus ();

  ctrlseq dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  step_t       q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          wplan[5];
  logic [16:0] prev_chk = '0;

  function automatic logic [15:0] ov(input logic [5:0] ie, input logic a, input logic r,
                                     input logic w, input logic io, input logic [1:0] s,
                                     input logic h, input logic [2:0] m);
    return {ie, a, r, w, io, s, h, m};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.ienb, bus.ale, bus.rd_, bus.wr_, bus.iom, bus.s1, bus.s0, bus.hlta, bus.mcyc};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [16:0] mk(input logic go6, input logic hlt, input logic dio,
                                     input logic [3:0] cyc, input logic [3:0] rw,
                                     input logic [3:0] cd);
    return {1'b0, cd, rw, cyc, dio, hlt, 1'b0, go6};
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    logic [15:0] got;
    got = obs();
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] e, input logic r, input logic [16:0] c);
    step_t s;
    s.exp = e;
    s.rdy = r;
    s.chk = c;
    q.push_back(s);
  endtask

  // Expected schedule for one instruction; chk_i keeps the previous word until M1 T4.
  task automatic build(input logic [16:0] chk);
    logic [3:0] cyc, rw, cd;
    logic       go6, hlt, dio, last, wr, hl, io;
    logic [2:0] m;
    logic [1:0] s;
    logic [5:0] base, t3;
    int         ms[$];
    int         k;
    cyc = chk[7:4];
    rw  = chk[11:8];
    cd  = chk[15:12];
    go6 = chk[0];
    hlt = chk[2];
    dio = chk[3];
    ms.push_back(0);
    k = 0;
    while (!hlt && k < 4 && cyc[k]) begin
      ms.push_back(k + 1);
      k++;
    end
    for (int i = 0; i < ms.size(); i++) begin
      m    = 3'(ms[i]);
      last = (i == ms.size() - 1);
      if (m == 3'd0) begin
        push(ov(6'd0, H, H, H, L, 2'b11, L, m), rbit(), prev_chk);
        for (int w = 0; w <= wplan[0]; w++)
          push(ov(6'd0, L, L, H, L, 2'b11, L, m), (w == wplan[0]), prev_chk);
        push(ov(B_COD | B_PC, L, L, H, L, 2'b11, L, m), rbit(), prev_chk);
        push(ov((last && !go6 && !hlt) ? (B_RRD | B_RWR) : 6'd0, L, H, H, L, 2'b11, L, m),
             rbit(), chk);
        if (hlt) begin
          repeat (3) push(ov(6'd0, L, H, H, L, 2'b00, H, 3'd0), rbit(), chk);
        end else if (go6) begin
          push(ov(6'd0, L, H, H, L, 2'b11, L, m), rbit(), chk);
          push(ov(last ? (B_RRD | B_RWR) : 6'd0, L, H, H, L, 2'b11, L, m), rbit(), chk);
        end
      end else begin
        wr   = rw[m-1];
        hl   = cd[m-1];
        io   = dio && (m == 3'd2);
        s    = wr ? 2'b01 : 2'b10;
        base = (hl ? B_PD : 6'd0) | (wr ? B_RRD : 6'd0);
        t3   = wr ? base : (base | B_DAT | (hl ? 6'd0 : B_PC) | (last ? B_RWR : 6'd0));
        push(ov(base, H, H, H, io, s, L, m), rbit(), chk);
        for (int w = 0; w <= wplan[m]; w++)
          push(ov(base, L, wr, ~wr, io, s, L, m), (w == wplan[m]), chk);
        push(ov(t3, L, wr, ~wr, io, s, L, m), rbit(), chk);
      end
    end
    prev_chk = chk;
  endtask

  // Applies up to lim steps; the last one optionally without the following clock edge.
  task automatic apply(input string name, input int lim, input bit edge_last);
    step_t s;
    int    n;
    n = 0;
    while (q.size() > 0 && (lim < 0 || n < lim)) begin
      s = q.pop_front();
      @(negedge clk);
      bus.ready = s.rdy;
      bus.chk_i = s.chk;
      #1;
      check($sformatf("%s[%0d]", name, n), s.exp);
      n++;
      if (edge_last || q.size() > 0 && (lim < 0 || n < lim)) @(posedge clk);
    end
  endtask

  task automatic do_reset(input string name);
    logic [15:0] idle;
    idle = ov(6'd0, L, H, H, L, 2'b11, L, 3'd0);
    rst_ = 1'b0;
    #1;
    check({name, "_asserted"}, idle);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    check({name, "_released"}, idle);
    prev_chk = '0;
    q.delete();
  endtask

  task automatic run(input string name, input logic [16:0] chk);
    build(chk);
    apply(name, -1, 1'b1);
  endtask

  initial begin
    logic [16:0] c;
    int          n;
    bus.ready = 1'b1;
    bus.chk_i = '0;
    foreach (wplan[i]) wplan[i] = 0;
    #2;
    do_reset("reset");

    run("mov_bc", mk(L, L, L, 4'b0000, 4'b0000, 4'b0000));
    run("mvi", mk(L, L, L, 4'b0001, 4'b0000, 4'b0000));
    run("mov_ma", mk(L, L, L, 4'b0001, 4'b0001, 4'b0001));
    wplan[0] = 2;
    run("mov_wait", mk(L, L, L, 4'b0000, 4'b0000, 4'b0000));
    wplan[0] = 0;
    run("inx", mk(H, L, L, 4'b0000, 4'b0000, 4'b0000));
    run("out", mk(L, L, H, 4'b0011, 4'b0010, 4'b0000));
    run("hlt", mk(L, H, L, 4'b0001, 4'b0000, 4'b0000));
    do_reset("hlt_reset");
    run("after_hlt", mk(L, L, L, 4'b0000, 4'b0000, 4'b0000));

    // Abort in the middle of M2 T2 of an MVI.
    build(mk(L, L, L, 4'b0001, 4'b0000, 4'b0000));
    apply("mvi_abort", 6, 1'b0);
    #2;
    do_reset("mid_reset");
    run("after_abort", mk(L, L, L, 4'b0001, 4'b0001, 4'b0000));

    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 4);
      c = mk(rbit(), L, rbit(), 4'((1 << n) - 1), 4'($urandom), 4'($urandom));
      c[INST_DAD] = rbit();
      c[INST_CCC] = rbit();
      foreach (wplan[j]) wplan[j] = $urandom_range(0, 2);
      run($sformatf("rand%0d", i), c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
